// File: rtl/mem2p_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem2p_pkg : shared types and constants for the mem2p two-port RAM          |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package mem2p_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem2p_state_t;

  localparam int LANE_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/mem2p_clear_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem2p_clear_fsm : post-reset clear sweep controller for mem2p              |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module mem2p_clear_fsm
  import mem2p_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  mem2p_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      if (ptr_q == LAST_ADDR) begin
        state_d = READY;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The clearing write must not land on the reset edge itself.
  assign clr_we   = (state_q == CLEAR) && !rst;
  assign clr_addr = ptr_q;
  assign busy     = (state_q == CLEAR);

endmodule
`default_nettype wire

// File: rtl/mem2p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem2p    : two-port synchronous RAM, byte-enabled write, registered read,  |
// |            automatic zero-clear sweep after every reset                    |
// | Options  : MEM2P_BYPASS_EN selects write-first data on address collision   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem2p
  import mem2p_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LANE       = LANE_DEFAULT,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NLANES     = WIDTH / LANE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [NLANES-1:0]     wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [WIDTH-1:0]      w_mem_wdata;
  logic [NLANES-1:0]     w_mem_be;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic [WIDTH-1:0]      w_rd_word;

  mem2p_clear_fsm #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .busy     (busy)
  );

  // Range checks only matter when DEPTH leaves unused address codes.
  if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
    assign w_wr_in_range = 1'b1;
    assign w_rd_in_range = 1'b1;
  end else begin : g_partial_range
    assign w_wr_in_range = (32'(wr_addr) < 32'(DEPTH));
    assign w_rd_in_range = (32'(rd_addr) < 32'(DEPTH));
  end

  always_comb begin
    w_mem_we    = wr_en && w_wr_in_range;
    w_mem_addr  = wr_addr;
    w_mem_wdata = wr_data;
    w_mem_be    = wr_be;
    if (busy) begin
      w_mem_we    = w_clr_we;
      w_mem_addr  = w_clr_addr;
      w_mem_wdata = '0;
      w_mem_be    = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < NLANES; i++) begin
        if (w_mem_be[i]) begin
          mem_q[w_mem_addr][i*LANE +: LANE] <= w_mem_wdata[i*LANE +: LANE];
        end
      end
    end
  end

  always_comb begin
    w_rd_word = w_rd_in_range ? mem_q[rd_addr] : '0;
`ifdef MEM2P_BYPASS_EN
    if (wr_en && w_wr_in_range && w_rd_in_range && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NLANES; i++) begin
        if (wr_be[i]) begin
          w_rd_word[i*LANE +: LANE] = wr_data[i*LANE +: LANE];
        end
      end
    end
`endif
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (!busy && rd_en) begin
      rd_data_d  = w_rd_word;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  a_no_valid_while_busy : assert property (@(posedge clk) disable iff (rst) busy |-> !rd_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_mem2p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem2p : scoreboard bench for mem2p (DEPTH=16 and DEPTH=12 instances)    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mem2p;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_wr_en, a_rd_en, a_rd_valid, a_busy;
  logic [3:0]  a_wr_addr, a_rd_addr, a_wr_be;
  logic [31:0] a_wr_data, a_rd_data;
  logic        b_rst, b_wr_en, b_rd_en, b_rd_valid, b_busy;
  logic [3:0]  b_wr_addr, b_rd_addr, b_wr_be;
  logic [31:0] b_wr_data, b_rd_data;

  mem2p #(.WIDTH(32), .LANE(8), .DEPTH(16)) u_dut_a (
    .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_be(a_wr_be), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .busy(a_busy)
  );

  mem2p #(.WIDTH(32), .LANE(8), .DEPTH(12)) u_dut_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_be(b_wr_be), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .busy(b_busy)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_a [16];
  logic [31:0] model_b [16];
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  bit          issue_a = 1'b0;
  bit          issue_b = 1'b0;
  bit          exp_va, exp_vb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    a_wr_en = 0; a_rd_en = 0; b_wr_en = 0; b_rd_en = 0;
    issue_a = 0; issue_b = 0;
    @(negedge clk);
  endtask

  // One cycle of traffic on one instance; expected read data comes from the model.
  task automatic drive(input bit sel_b, input bit we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input bit re, input logic [3:0] ra);
    int          dep;
    logic [31:0] exp;
    dep = sel_b ? 12 : 16;
    a_wr_en = 0; a_rd_en = 0; b_wr_en = 0; b_rd_en = 0;
    issue_a = 0; issue_b = 0;
    if (sel_b) begin
      b_wr_en = we; b_wr_addr = wa; b_wr_data = wd; b_wr_be = be; b_rd_en = re; b_rd_addr = ra;
      issue_b = re;
    end else begin
      a_wr_en = we; a_wr_addr = wa; a_wr_data = wd; a_wr_be = be; a_rd_en = re; a_rd_addr = ra;
      issue_a = re;
    end
    if (re) begin
      exp = (int'(ra) < dep) ? (sel_b ? model_b[ra] : model_a[ra]) : 32'h0;
`ifdef MEM2P_BYPASS_EN
      if (we && wa == ra && int'(ra) < dep)
        for (int i = 0; i < 4; i++) if (be[i]) exp[i*8 +: 8] = wd[i*8 +: 8];
`endif
      if (sel_b) q_b.push_back(exp); else q_a.push_back(exp);
    end
    if (we && int'(wa) < dep) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          if (sel_b) model_b[wa][i*8 +: 8] = wd[i*8 +: 8];
          else       model_a[wa][i*8 +: 8] = wd[i*8 +: 8];
        end
      end
    end
    @(negedge clk);
  endtask

  // Releases a_rst and counts cycles until busy drops, attempting traffic meanwhile.
  task automatic count_clear_a(output int n);
    n = 0;
    a_rst = 0;
    while (a_busy && n < 100) begin
      a_rd_en = 1; a_rd_addr = 4'(n); a_wr_en = 1; a_wr_addr = 4'd3;
      a_wr_data = 32'hFFFF_FFFF; a_wr_be = 4'hF;
      @(negedge clk);
      n++;
      if (!a_busy) begin a_rd_en = 0; a_wr_en = 0; end
    end
    a_rd_en = 0; a_wr_en = 0;
  endtask

  always @(posedge clk) begin
    exp_va = issue_a;
    exp_vb = issue_b;
    #1;
    chk("a_valid", {31'b0, a_rd_valid}, {31'b0, exp_va});
    if (a_rd_valid && q_a.size() > 0) chk("a_data", a_rd_data, q_a.pop_front());
    chk("b_valid", {31'b0, b_rd_valid}, {31'b0, exp_vb});
    if (b_rd_valid && q_b.size() > 0) chk("b_data", b_rd_data, q_b.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int na, nb, n;
    for (int i = 0; i < 16; i++) begin model_a[i] = 0; model_b[i] = 0; end
    a_rst = 1; b_rst = 1;
    a_wr_en = 0; a_rd_en = 0; a_wr_addr = 0; a_rd_addr = 0; a_wr_data = 0; a_wr_be = 0;
    b_wr_en = 0; b_rd_en = 0; b_wr_addr = 0; b_rd_addr = 0; b_wr_data = 0; b_wr_be = 0;
    repeat (2) @(negedge clk);
    chk("rst_data", a_rd_data, 32'h0);
    chk("rst_busy", {31'b0, a_busy}, 32'h1);
    chk("rst_busy_b", {31'b0, b_busy}, 32'h1);

    // Release both; attempted traffic during the sweep must be ignored.
    a_rst = 0; b_rst = 0; na = 0; nb = 0; n = 0;
    a_rd_en = 1; a_wr_en = 1; a_wr_addr = 4'd3; a_wr_data = 32'hFFFF_FFFF; a_wr_be = 4'hF;
    b_rd_en = 1; b_wr_en = 1; b_wr_addr = 4'd1; b_wr_data = 32'hFFFF_FFFF; b_wr_be = 4'hF;
    while ((a_busy || b_busy) && n < 100) begin
      @(negedge clk);
      n++;
      if (!a_busy && na == 0) begin na = n; a_rd_en = 0; a_wr_en = 0; end
      if (!b_busy && nb == 0) begin nb = n; b_rd_en = 0; b_wr_en = 0; end
    end
    chk("clear_len_16", 32'(na), 32'd16);
    chk("clear_len_12", 32'(nb), 32'd12);
    idle();

    // Back-to-back reads of every address: all zero, no gaps.
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 0, 1, 4'(i));
    idle();

    // Byte-enable merge.
    drive(0, 1, 4'd3, 32'hDEAD_BEEF, 4'b1111, 0, 0);
    drive(0, 1, 4'd3, 32'h1122_3344, 4'b0101, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 4'd3);
    idle();
    chk("be_merge", a_rd_data, 32'hDE22_BE44);

    // Reset mid-traffic clears the output register.
    a_rst = 1;
    @(negedge clk);
    chk("rst2_data", a_rd_data, 32'h0);
    chk("rst2_busy", {31'b0, a_busy}, 32'h1);
    for (int i = 0; i < 16; i++) model_a[i] = 0;

    // Reset again at sweep pointer 9.
    a_rst = 0;
    repeat (9) @(negedge clk);
    a_rst = 1;
    @(negedge clk);
    count_clear_a(n);
    chk("resweep_len", 32'(n), 32'd16);
    idle();
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 0, 1, 4'(i));
    idle();

    // Collision on address 5.
    drive(0, 1, 4'd5, 32'hAAAA_AAAA, 4'b1111, 0, 0);
    drive(0, 1, 4'd5, 32'h5555_5555, 4'b0011, 1, 4'd5);
    idle();
`ifdef MEM2P_BYPASS_EN
    chk("collide", a_rd_data, 32'hAAAA_5555);
`else
    chk("collide", a_rd_data, 32'hAAAA_AAAA);
`endif
    drive(0, 0, 0, 0, 0, 1, 4'd5);
    idle();
    chk("after_collide", a_rd_data, 32'hAAAA_5555);

    // Different-address read and write in the same cycle.
    drive(0, 1, 4'd7, 32'h1234_5678, 4'b1111, 1, 4'd5);
    drive(0, 0, 0, 0, 0, 1, 4'd7);
    idle();
    chk("diff_addr", a_rd_data, 32'h1234_5678);

    // Random mixed traffic.
    for (int i = 0; i < 40; i++)
      drive(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    idle();

    // Out-of-range access on the DEPTH=12 instance.
    drive(1, 1, 4'd1, 32'hCAFE_F00D, 4'b1111, 0, 0);
    drive(1, 1, 4'd13, 32'hFFFF_FFFF, 4'b1111, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 4'd13);
    idle();
    chk("oor_read", b_rd_data, 32'h0);
    drive(1, 0, 0, 0, 0, 1, 4'd1);
    idle();
    chk("oor_addr1", b_rd_data, 32'hCAFE_F00D);
    for (int i = 0; i < 16; i++) drive(1, 0, 0, 0, 0, 1, 4'(i));
    idle();
    idle();

    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
